wb_port_arbiter: RTL

//  Shares the single register-file write port between the in-order pipeline

---
 rtl/wb_port_arbiter_pkg.sv | 22 ++
 rtl/wb_port_arbiter_if.sv | 45 ++++
 rtl/wb_port_arbiter_age_counter.sv | 37 +++
 rtl/wb_port_arbiter.sv | 107 ++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and helpers for the register-file write-port arbiter.
package wb_pkg;

    typedef enum logic {
        WB_SRC_PIPE = 1'b0,
        WB_SRC_LU   = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    localparam int WB_REG_WRITE_BIT  = 1;
    localparam int WB_MEM_TO_REG_BIT = 0;

    // Width of a counter that must hold 0..max_wait; never narrower than one bit.
    function automatic int wait_width(input int max_wait);
        return (max_wait < 2) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the MEM/WB stage, the long-latency unit and the register-file write port.
interface wb_port_arbiter_if import wb_pkg::*; #(
    parameter int DATA_WIDTH   = 64,
    parameter int REG_ID_WIDTH = 5,
    parameter int MAX_WAIT     = 4,
    parameter int PERF_WIDTH   = 32
) ();

    localparam int WAIT_W = wait_width(MAX_WAIT);

    logic [1:0]              pipe_wb_ctrl;
    logic [DATA_WIDTH-1:0]   pipe_alu;
    logic [DATA_WIDTH-1:0]   pipe_mem_data;
    logic [REG_ID_WIDTH-1:0] pipe_dest;
    logic                    pipe_stall;

    // lu handshake: a result transfers on any cycle where lu_valid && lu_ready;
    // lu_dest/lu_data stay stable while lu_valid && !lu_ready.
    logic                    lu_valid;
    logic [REG_ID_WIDTH-1:0] lu_dest;
    logic [DATA_WIDTH-1:0]   lu_data;
    logic                    lu_ready;

    logic                    rf_we;
    logic [REG_ID_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0]   rf_wdata;
    logic                    rf_src;
    logic [PERF_WIDTH-1:0]   perf_stalls;
    logic [WAIT_W-1:0]       dbg_wait_cnt;

    modport slave (
        input  pipe_wb_ctrl, pipe_alu, pipe_mem_data, pipe_dest,
        input  lu_valid, lu_dest, lu_data,
        output pipe_stall, lu_ready,
        output rf_we, rf_waddr, rf_wdata, rf_src, perf_stalls, dbg_wait_cnt
    );

    modport master (
        output pipe_wb_ctrl, pipe_alu, pipe_mem_data, pipe_dest,
        output lu_valid, lu_dest, lu_data,
        input  pipe_stall, lu_ready,
        input  rf_we, rf_waddr, rf_wdata, rf_src, perf_stalls, dbg_wait_cnt
    );

endinterface

// File: rtl/wb_port_arbiter_age_counter.sv
// Saturating age counter: counts refused cycles, clears on demand, flags the ceiling.
module wb_age_counter import wb_pkg::*; #(
    parameter int MAX = 4,
    parameter int W   = wait_width(MAX)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_max) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign at_max = (cnt_q == W'(MAX));

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, the long-latency
// unit wins after MAX_WAIT refusals by stalling the pipeline for one grant.
module wb_port_arbiter import wb_pkg::*; #(
    parameter int DATA_WIDTH   = 64,
    parameter int REG_ID_WIDTH = 5,
    parameter int MAX_WAIT     = 4,
    parameter int PERF_WIDTH   = 32
) (
    input logic              clk,
    input logic              reset,
    wb_port_arbiter_if.slave bus
);

    localparam int WAIT_W = wait_width(MAX_WAIT);

    wb_ctrl_t                pipe_ctrl;
    logic                    pipe_req;
    logic [DATA_WIDTH-1:0]   pipe_data;
    logic                    lu_req;
    logic                    lu_drop;
    logic                    lu_grant;
    logic                    pipe_grant;
    logic                    stall;
    logic                    wait_inc;
    logic                    wait_clr;
    logic                    wait_at_max;
    logic [WAIT_W-1:0]       wait_cnt;

    logic                    rf_we_d,       rf_we_q;
    logic [REG_ID_WIDTH-1:0] rf_waddr_d,    rf_waddr_q;
    logic [DATA_WIDTH-1:0]   rf_wdata_d,    rf_wdata_q;
    wb_src_e                 rf_src_d,      rf_src_q;
    logic [PERF_WIDTH-1:0]   perf_stalls_d, perf_stalls_q;

    // Writes to x0 from either side never request the port.
    always_comb begin
        pipe_ctrl  = wb_ctrl_t'(bus.pipe_wb_ctrl);
        pipe_req   = pipe_ctrl.reg_write && (bus.pipe_dest != '0);
        pipe_data  = pipe_ctrl.mem_to_reg ? bus.pipe_mem_data : bus.pipe_alu;
        lu_req     = bus.lu_valid && (bus.lu_dest != '0);
        lu_drop    = bus.lu_valid && (bus.lu_dest == '0);
        lu_grant   = lu_req && (!pipe_req || wait_at_max);
        pipe_grant = pipe_req && !lu_grant;
        stall      = lu_grant && pipe_req;
        wait_inc   = lu_req && !lu_grant;
        wait_clr   = !wait_inc;
    end

    wb_age_counter #(
        .MAX (MAX_WAIT),
        .W   (WAIT_W)
    ) u_wait_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (wait_clr),
        .inc    (wait_inc),
        .cnt    (wait_cnt),
        .at_max (wait_at_max)
    );

    always_comb begin
        rf_we_d       = lu_grant || pipe_grant;
        rf_waddr_d    = rf_waddr_q;
        rf_wdata_d    = rf_wdata_q;
        rf_src_d      = rf_src_q;
        perf_stalls_d = perf_stalls_q;
        if (lu_grant) begin
            rf_waddr_d = bus.lu_dest;
            rf_wdata_d = bus.lu_data;
            rf_src_d   = WB_SRC_LU;
        end else if (pipe_grant) begin
            rf_waddr_d = bus.pipe_dest;
            rf_wdata_d = pipe_data;
            rf_src_d   = WB_SRC_PIPE;
        end
        if (stall && (perf_stalls_q != '1)) begin
            perf_stalls_d = perf_stalls_q + PERF_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
            rf_src_q      <= WB_SRC_PIPE;
            perf_stalls_q <= '0;
        end else begin
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            rf_src_q      <= rf_src_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    // Handshake outputs are forced low while reset is held.
    assign bus.lu_ready     = reset && (lu_grant || lu_drop);
    assign bus.pipe_stall   = reset && stall;
    assign bus.rf_we        = rf_we_q;
    assign bus.rf_waddr     = rf_waddr_q;
    assign bus.rf_wdata     = rf_wdata_q;
    assign bus.rf_src       = rf_src_q;
    assign bus.perf_stalls  = perf_stalls_q;
    assign bus.dbg_wait_cnt = wait_cnt;

endmodule
